i2c_master: RTL and testbench
=============================

I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 Parameter SCL_FRE, default 10: clk cycles per SCL bit period; even, >=8.
REQ-002 Parameter DEV_ADDR, default 7'b1010000: 7-bit EEPROM device address; write byte = {DEV_ADDR,0}, read byte = {DEV_ADDR,1}.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start_wr  input  1  one-cycle request for a single-byte write.
REQ-006 start_rd  input  1  one-cycle request for a single-byte random read.
REQ-007 reg_addr  input  8  EEPROM register address; captured at request acceptance.
REQ-008 wr_data  input  8  write payload; captured at request acceptance.
REQ-009 rd_data  output  8  byte returned by a read; holds until the next read completes.
REQ-010 rd_valid  output  1  one-cycle pulse when rd_data is updated.
REQ-011 done  output  1  one-cycle pulse at the end of any transaction, including aborted ones.
REQ-012 busy  output  1  high while a transaction is in progress.
REQ-013 ack_err  output  1  high if the last transaction saw a NACK; cleared when the next request is accepted.
REQ-014 eeprom_scl_o  output  1  SCL to the EEPROM model.
REQ-015 eeprom_sda  inout  1  SDA; the master drives it only when i2c_sda_en=0, else releases it to Z.
REQ-016 i2c_sda_en  output  1  SDA ownership: 1 = the slave drives SDA (ACK slots, read data bits); 0 = the master drives.
REQ-017 i2c_write_req  output  1  high for the entire duration of an accepted write.
REQ-018 i2c_read_req  output  1  high for the entire duration of an accepted read.

Function
REQ-019 State set: IDLE, START, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RSTART, RD_DEV, RD_DEV_ACK, RD_DATA, RD_NACK, STOP.
REQ-020 Each non-IDLE state lasts whole bit periods.
- Bit counter scl_cnt runs 0..SCL_FRE-1 and wraps.
- Byte states last 8 periods; bits are sent MSB first.
REQ-021 Data bit timing:
- eeprom_scl_o = 0 for scl_cnt < SCL_FRE/2, else 1.
- The master changes SDA only at scl_cnt=0.
- The master samples SDA at scl_cnt = SCL_FRE/2 + 1.
REQ-022 START and RSTART (1 period each):
- SCL is high for the whole period.
- SDA is 1 for scl_cnt < SCL_FRE/2, then 0.
REQ-023 STOP (1 period):
- SDA = 0 throughout, except SDA = 1 when scl_cnt >= SCL_FRE/2 + 2.
- SCL is low for the first half of the period, high for the second half.
REQ-024 IDLE: eeprom_scl_o = 1, SDA driven to 1, i2c_sda_en = 0.
REQ-025 i2c_sda_en = 1 only in DEV_ACK, REG_ACK, WR_ACK, RD_DEV_ACK and RD_DATA; 0 everywhere else.
REQ-026 Write sequence: START → DEV_ADDR → DEV_ACK → REG_ADDR → REG_ACK → WR_DATA → WR_ACK → STOP → IDLE. Total 29 bit periods.
REQ-027 Read sequence: START → DEV_ADDR → DEV_ACK → REG_ADDR → REG_ACK → RSTART → RD_DEV → RD_DEV_ACK → RD_DATA → RD_NACK → STOP → IDLE. Total 39 bit periods.
- In RD_NACK the master drives SDA = 1.
REQ-028 ACK slot handling: if SDA sampled in an ACK state is 1:
- set ack_err;
- next state is STOP at the end of that period.
REQ-029 RD_DATA shifts each sampled bit in MSB first. At RD_NACK entry: rd_data is loaded and rd_valid pulses for one cycle.
REQ-030 Request acceptance:
- A request is accepted only in IDLE with busy = 0.
- busy, START and the matching req output all go high the cycle after the request.
REQ-031 If start_wr and start_rd are high in the same cycle, the write is accepted and the read is dropped.
REQ-032 Requests arriving while busy = 1 are ignored; they are not queued.
REQ-033 Leaving STOP:
- done pulses on the final cycle of STOP.
- busy, i2c_write_req and i2c_read_req drop on the following cycle.
- A new request is accepted in that same following cycle.
REQ-034 Latency from request to done: 29*SCL_FRE clocks for a write, 39*SCL_FRE for a read (290/390 at default), or fewer on abort.

Reset
REQ-035 While reset = 1, at the next clk edge, from any state including mid-transaction:
- state = IDLE, counters = 0;
- eeprom_scl_o = 1, SDA driven 1, i2c_sda_en = 0;
- busy, done, rd_valid, ack_err, i2c_write_req, i2c_read_req = 0;
- rd_data = 8'h00.
REQ-036 Reset mid-transaction issues no STOP; the bus returns to IDLE levels immediately.

Verification
REQ-037 Write path: start_wr, reg_addr = 8'h3C, wr_data = 8'h5A, slave ACKs every slot → SDA bytes observed: 8'hA0, 8'h3C, 8'h5A; done exactly 290 clocks after the request; ack_err = 0.
REQ-038 Read path: start_rd, reg_addr = 8'h3C, slave returns 8'hA5 → bytes observed: 8'hA0, 8'h3C, repeated START, 8'hA1; master NACK; rd_data = 8'hA5 with a single rd_valid pulse; done at 390 clocks.
REQ-039 NACK: slave leaves SDA = 1 in DEV_ACK → ack_err = 1, STOP follows immediately, done at (1 + 9 + 1)*SCL_FRE = 110 clocks; the next request clears ack_err.
REQ-040 Simultaneous start_wr and start_rd → only the write runs; i2c_read_req stays 0 throughout.
REQ-041 start_rd pulsed mid-write → ignored; exactly one done.
REQ-042 reset asserted during REG_ADDR → next cycle: IDLE outputs as in REQ-035; a following start_wr completes normally.

Source files
------------

// File: rtl/i2c_master.sv
// I2C master for a single-byte EEPROM write or a single-byte random read.
// The bus is timed by a per-bit clock counter. SCL and SDA are decoded from
// the registered state and count, so each bus edge lands on a fixed count.
module i2c_master #(
  parameter int         SCL_FRE  = 10,
  parameter logic [6:0] DEV_ADDR = 7'b1010000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start_wr,
  input  logic       i_start_rd,
  input  logic [7:0] i_reg_addr,
  input  logic [7:0] i_wr_data,
  output logic [7:0] o_rd_data,
  output logic       o_rd_valid,
  output logic       o_done,
  output logic       o_busy,
  output logic       o_ack_err,
  output logic       o_eeprom_scl,
  inout  wire        io_eeprom_sda,
  output logic       o_i2c_sda_en,
  output logic       o_i2c_write_req,
  output logic       o_i2c_read_req
);

  localparam int CW = $clog2(SCL_FRE);
  localparam logic [CW-1:0] HALF_C     = CW'(SCL_FRE / 2);
  localparam logic [CW-1:0] SAMP_C     = CW'(SCL_FRE / 2 + 1);
  localparam logic [CW-1:0] STOP_HI_C  = CW'(SCL_FRE / 2 + 2);
  localparam logic [CW-1:0] PRE_LAST_C = CW'(SCL_FRE - 2);
  localparam logic [CW-1:0] LAST_C     = CW'(SCL_FRE - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_REG_ADDR,
    ST_REG_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RSTART,
    ST_RD_DEV,
    ST_RD_DEV_ACK,
    ST_RD_DATA,
    ST_RD_NACK,
    ST_STOP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_scl_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_tx;
  logic [7:0]    r_rx;
  logic [7:0]    r_reg_addr;
  logic [7:0]    r_wr_data;
  logic          r_nack;
  logic [7:0]    r_rd_data;
  logic          r_rd_valid;
  logic          r_done;
  logic          r_busy;
  logic          r_ack_err;
  logic          r_write_req;
  logic          r_read_req;

  logic w_scl;
  logic w_sda_out;
  logic w_sda_en;
  logic w_sda_in;
  logic w_ack_slot;
  logic w_scl_high;

  assign w_sda_in   = io_eeprom_sda;
  assign w_scl_high = (r_scl_cnt >= HALF_C);
  assign w_ack_slot = (r_state == ST_DEV_ACK) || (r_state == ST_REG_ACK) ||
                      (r_state == ST_WR_ACK)  || (r_state == ST_RD_DEV_ACK);

  // Bus levels and SDA ownership as a function of where we are in the bit period
  always_comb begin
    w_scl     = 1'b1;
    w_sda_out = 1'b1;
    w_sda_en  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_scl     = 1'b1;
        w_sda_out = 1'b1;
      end
      ST_START, ST_RSTART: begin
        w_scl     = 1'b1;
        w_sda_out = (r_scl_cnt < HALF_C);
      end
      ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA, ST_RD_DEV: begin
        w_scl     = w_scl_high;
        w_sda_out = r_tx[7];
      end
      ST_DEV_ACK, ST_REG_ACK, ST_WR_ACK, ST_RD_DEV_ACK, ST_RD_DATA: begin
        w_scl    = w_scl_high;
        w_sda_en = 1'b1;
      end
      ST_RD_NACK: begin
        w_scl     = w_scl_high;
        w_sda_out = 1'b1;
      end
      ST_STOP: begin
        w_scl     = w_scl_high;
        w_sda_out = (r_scl_cnt >= STOP_HI_C);
      end
      default: begin
        w_scl     = 1'b1;
        w_sda_out = 1'b1;
      end
    endcase
  end

  assign io_eeprom_sda   = w_sda_en ? 1'bz : w_sda_out;
  assign o_eeprom_scl    = w_scl;
  assign o_i2c_sda_en    = w_sda_en;
  assign o_rd_data       = r_rd_data;
  assign o_rd_valid      = r_rd_valid;
  assign o_done          = r_done;
  assign o_busy          = r_busy;
  assign o_ack_err       = r_ack_err;
  assign o_i2c_write_req = r_write_req;
  assign o_i2c_read_req  = r_read_req;

  // Transaction sequencer: accepts requests in IDLE and steps one bit period at a time
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_scl_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_reg_addr  <= '0;
      r_wr_data   <= '0;
      r_nack      <= 1'b0;
      r_rd_data   <= 8'h00;
      r_rd_valid  <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_ack_err   <= 1'b0;
      r_write_req <= 1'b0;
      r_read_req  <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      if (r_state == ST_IDLE) begin
        r_scl_cnt <= '0;
        r_bit_cnt <= '0;
        if (i_start_wr || i_start_rd) begin
          r_state     <= ST_START;
          r_busy      <= 1'b1;
          r_ack_err   <= 1'b0;
          r_write_req <= i_start_wr;
          r_read_req  <= !i_start_wr;
          r_reg_addr  <= i_reg_addr;
          r_wr_data   <= i_wr_data;
        end
      end else begin
        if (r_scl_cnt == SAMP_C) begin
          if (w_ack_slot) begin
            r_nack <= w_sda_in;
          end
          if (r_state == ST_RD_DATA) begin
            r_rx <= {r_rx[6:0], w_sda_in};
          end
        end
        if ((r_state == ST_STOP) && (r_scl_cnt == PRE_LAST_C)) begin
          r_done <= 1'b1;
        end
        if (r_scl_cnt != LAST_C) begin
          r_scl_cnt <= r_scl_cnt + CW'(1);
        end else begin
          r_scl_cnt <= '0;
          case (r_state)
            ST_START: begin
              r_state   <= ST_DEV_ADDR;
              r_tx      <= {DEV_ADDR, 1'b0};
              r_bit_cnt <= '0;
            end
            ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA, ST_RD_DEV: begin
              if (r_bit_cnt == 3'd7) begin
                r_bit_cnt <= '0;
                r_state   <= (r_state == ST_DEV_ADDR) ? ST_DEV_ACK :
                             (r_state == ST_REG_ADDR) ? ST_REG_ACK :
                             (r_state == ST_WR_DATA)  ? ST_WR_ACK  : ST_RD_DEV_ACK;
              end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_tx      <= {r_tx[6:0], 1'b0};
              end
            end
            ST_DEV_ACK: begin
              if (r_nack) begin
                r_ack_err <= 1'b1;
                r_state   <= ST_STOP;
              end else begin
                r_state <= ST_REG_ADDR;
                r_tx    <= r_reg_addr;
              end
            end
            ST_REG_ACK: begin
              if (r_nack) begin
                r_ack_err <= 1'b1;
                r_state   <= ST_STOP;
              end else if (r_read_req) begin
                r_state <= ST_RSTART;
              end else begin
                r_state <= ST_WR_DATA;
                r_tx    <= r_wr_data;
              end
            end
            ST_WR_ACK: begin
              if (r_nack) begin
                r_ack_err <= 1'b1;
              end
              r_state <= ST_STOP;
            end
            ST_RSTART: begin
              r_state   <= ST_RD_DEV;
              r_tx      <= {DEV_ADDR, 1'b1};
              r_bit_cnt <= '0;
            end
            ST_RD_DEV_ACK: begin
              if (r_nack) begin
                r_ack_err <= 1'b1;
                r_state   <= ST_STOP;
              end else begin
                r_state   <= ST_RD_DATA;
                r_bit_cnt <= '0;
              end
            end
            ST_RD_DATA: begin
              if (r_bit_cnt == 3'd7) begin
                r_bit_cnt  <= '0;
                r_state    <= ST_RD_NACK;
                r_rd_data  <= r_rx;
                r_rd_valid <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
              end
            end
            ST_RD_NACK: begin
              r_state <= ST_STOP;
            end
            ST_STOP: begin
              r_state     <= ST_IDLE;
              r_busy      <= 1'b0;
              r_write_req <= 1'b0;
              r_read_req  <= 1'b0;
            end
            default: begin
              r_state <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master with a small EEPROM slave model on the bus.
// The slave ACKs, optionally NACKs one slot, and returns a fixed read byte.
module tb_i2c_master;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       startWr = 1'b0;
  logic       startRd = 1'b0;
  logic [7:0] regAddr = 8'h00;
  logic [7:0] wrData = 8'h00;
  wire  [7:0] rdData;
  wire        rdValid;
  wire        done;
  wire        busy;
  wire        ackErr;
  wire        scl;
  wire        sdaEn;
  wire        writeReq;
  wire        readReq;
  wire        sda;

  logic slaveBit = 1'b0;
  assign sda = sdaEn ? slaveBit : 1'bz;

  i2c_master #(.SCL_FRE(10), .DEV_ADDR(7'b1010000)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_start_wr      (startWr),
    .i_start_rd      (startRd),
    .i_reg_addr      (regAddr),
    .i_wr_data       (wrData),
    .o_rd_data       (rdData),
    .o_rd_valid      (rdValid),
    .o_done          (done),
    .o_busy          (busy),
    .o_ack_err       (ackErr),
    .o_eeprom_scl    (scl),
    .io_eeprom_sda   (sda),
    .o_i2c_sda_en    (sdaEn),
    .o_i2c_write_req (writeReq),
    .o_i2c_read_req  (readReq)
  );

  // Free-running clock
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int doneCount = 0;
  int rdValidCount = 0;
  int readReqCount = 0;
  int startCount = 0;
  int stopCount = 0;
  int riseCount = 0;
  bit curSeg = 1'b0;
  bit inTxn = 1'b0;
  logic prevScl = 1'b1;
  logic prevSda = 1'b1;
  logic [31:0] segBits [2] = '{32'h0, 32'h0};
  int nackSlot = -1;
  logic [7:0] rdByte = 8'hA5;

  logic acceptBusy, acceptWreq, acceptRreq, acceptAckErr;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic slaveValue(input int idx);
    if (curSeg && idx >= 9 && idx <= 16) return rdByte[3'(16 - idx)];
    if (!curSeg && idx == nackSlot) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] segByte(input bit s, input int first);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 8; i++) b[3'(7 - i)] = segBits[s][5'(first + i)];
    return b;
  endfunction

  // Bus monitor and slave: detects START/STOP, logs bits on SCL rise, sets slave data on SCL fall
  always @(negedge clk) begin
    if (!busy) inTxn = 1'b0;
    if (scl && prevScl && prevSda && !sda) begin
      startCount++;
      curSeg = inTxn;
      if (!inTxn) begin
        segBits[0] = 32'h0;
        segBits[1] = 32'h0;
      end
      inTxn = 1'b1;
      riseCount = 0;
    end else if (scl && prevScl && !prevSda && sda) begin
      stopCount++;
    end
    if (scl && !prevScl) begin
      if (riseCount < 32) segBits[curSeg][5'(riseCount)] = sda;
      riseCount++;
    end
    if (!scl && prevScl) slaveBit = slaveValue(riseCount);
    if (done) doneCount++;
    if (rdValid) rdValidCount++;
    if (readReq) readReqCount++;
    prevScl = scl;
    prevSda = sda;
  end

  task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] addr,
                               input logic [7:0] data, input int rdPulseAt, input int abortAt,
                               output int latency);
    startWr = wr;
    startRd = rd;
    regAddr = addr;
    wrData  = data;
    latency = 0;
    while (latency < 1000) begin
      @(posedge clk);
      #1;
      latency++;
      if (latency == 1) begin
        startWr = 1'b0;
        startRd = 1'b0;
        acceptBusy   = busy;
        acceptWreq   = writeReq;
        acceptRreq   = readReq;
        acceptAckErr = ackErr;
      end
      if (latency == rdPulseAt) startRd = 1'b1;
      else if (latency == rdPulseAt + 1) startRd = 1'b0;
      if (latency == abortAt) begin
        reset = 1'b1;
        return;
      end
      if (done) return;
    end
  endtask

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    int lat;
    int d0, s0, st0, rv0, rr0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_scl", 32'(scl), 32'd1);
    checkOutput("rst_sda", 32'(sda), 32'd1);
    checkOutput("rst_sda_en", 32'(sdaEn), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_rd_valid", 32'(rdValid), 32'd0);
    checkOutput("rst_ack_err", 32'(ackErr), 32'd0);
    checkOutput("rst_reqs", 32'({writeReq, readReq}), 32'd0);
    checkOutput("rst_rd_data", 32'(rdData), 32'h00);
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] write 0x5A to 0x3C");
    d0 = doneCount; s0 = stopCount;
    applyStimulus(1'b1, 1'b0, 8'h3C, 8'h5A, 0, 0, lat);
    checkOutput("wr_latency", 32'(lat), 32'd290);
    checkOutput("wr_accept_busy", 32'(acceptBusy), 32'd1);
    checkOutput("wr_accept_wreq", 32'(acceptWreq), 32'd1);
    checkOutput("wr_accept_rreq", 32'(acceptRreq), 32'd0);
    checkOutput("wr_byte_dev", 32'(segByte(1'b0, 0)), 32'hA0);
    checkOutput("wr_byte_reg", 32'(segByte(1'b0, 9)), 32'h3C);
    checkOutput("wr_byte_data", 32'(segByte(1'b0, 18)), 32'h5A);
    checkOutput("wr_ack_err", 32'(ackErr), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("wr_done_pulse", 32'(done), 32'd0);
    checkOutput("wr_busy_drop", 32'(busy), 32'd0);
    checkOutput("wr_wreq_drop", 32'(writeReq), 32'd0);
    checkOutput("wr_done_count", 32'(doneCount - d0), 32'd1);
    checkOutput("wr_stop_count", 32'(stopCount - s0), 32'd1);

    $display("[TB] read from 0x3C, back to back");
    st0 = startCount; rv0 = rdValidCount;
    applyStimulus(1'b0, 1'b1, 8'h3C, 8'h00, 0, 0, lat);
    checkOutput("rd_latency", 32'(lat), 32'd390);
    checkOutput("rd_accept_rreq", 32'(acceptRreq), 32'd1);
    checkOutput("rd_accept_wreq", 32'(acceptWreq), 32'd0);
    checkOutput("rd_byte_dev", 32'(segByte(1'b0, 0)), 32'hA0);
    checkOutput("rd_byte_reg", 32'(segByte(1'b0, 9)), 32'h3C);
    checkOutput("rd_byte_rddev", 32'(segByte(1'b1, 0)), 32'hA1);
    checkOutput("rd_master_nack", 32'(segBits[1][17]), 32'd1);
    checkOutput("rd_start_count", 32'(startCount - st0), 32'd2);
    checkOutput("rd_data", 32'(rdData), 32'hA5);
    checkOutput("rd_valid_count", 32'(rdValidCount - rv0), 32'd1);
    checkOutput("rd_ack_err", 32'(ackErr), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] NACK on device address");
    nackSlot = 8;
    d0 = doneCount; s0 = stopCount;
    applyStimulus(1'b1, 1'b0, 8'h3C, 8'h5A, 0, 0, lat);
    checkOutput("nack_latency", 32'(lat), 32'd110);
    checkOutput("nack_ack_err", 32'(ackErr), 32'd1);
    @(posedge clk);
    #1;
    nackSlot = -1;
    checkOutput("nack_done_count", 32'(doneCount - d0), 32'd1);
    checkOutput("nack_stop_count", 32'(stopCount - s0), 32'd1);
    checkOutput("nack_err_holds", 32'(ackErr), 32'd1);

    $display("[TB] simultaneous write and read request");
    rr0 = readReqCount;
    applyStimulus(1'b1, 1'b1, 8'h10, 8'h22, 0, 0, lat);
    checkOutput("both_err_cleared", 32'(acceptAckErr), 32'd0);
    checkOutput("both_accept_wreq", 32'(acceptWreq), 32'd1);
    checkOutput("both_accept_rreq", 32'(acceptRreq), 32'd0);
    checkOutput("both_latency", 32'(lat), 32'd290);
    checkOutput("both_rreq_never", 32'(readReqCount - rr0), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] read request pulsed mid-write");
    d0 = doneCount; rr0 = readReqCount;
    applyStimulus(1'b1, 1'b0, 8'h44, 8'h99, 50, 0, lat);
    checkOutput("mid_latency", 32'(lat), 32'd290);
    repeat (50) @(posedge clk);
    #1;
    checkOutput("mid_done_count", 32'(doneCount - d0), 32'd1);
    checkOutput("mid_rreq_never", 32'(readReqCount - rr0), 32'd0);
    checkOutput("mid_busy_idle", 32'(busy), 32'd0);
    checkOutput("mid_rd_data_hold", 32'(rdData), 32'hA5);

    $display("[TB] reset during register address");
    applyStimulus(1'b1, 1'b0, 8'h77, 8'h11, 0, 120, lat);
    @(posedge clk);
    #1;
    checkOutput("abort_scl", 32'(scl), 32'd1);
    checkOutput("abort_sda", 32'(sda), 32'd1);
    checkOutput("abort_sda_en", 32'(sdaEn), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_wreq", 32'(writeReq), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_rd_data", 32'(rdData), 32'h00);
    reset = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 8'hC3, 8'h96, 0, 0, lat);
    checkOutput("post_latency", 32'(lat), 32'd290);
    checkOutput("post_byte_dev", 32'(segByte(1'b0, 0)), 32'hA0);
    checkOutput("post_byte_reg", 32'(segByte(1'b0, 9)), 32'hC3);
    checkOutput("post_byte_data", 32'(segByte(1'b0, 18)), 32'h96);
    checkOutput("post_ack_err", 32'(ackErr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
